// File: rtl/sparse_act_encoder.sv
// sparse_act_encoder
// Compresses a dense stream of signed activations, one channel plane at a
// time, into (value, zero-run index) entries. A single output register gives
// 1-cycle latency and full throughput. Each plane closes with exactly one
// out_last entry, and its entry count is reported on cnt/cnt_valid.
// Optional build macro: SPARSE_ENC_RELU_EN clamps negative inputs to zero
// before encoding.
module sparse_act_encoder #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_value,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              cnt_valid,
    output logic [CNT_W-1:0]  cnt,
    output logic              cnt_ovf
);

    localparam logic [IDX_W-1:0]  ZR_MAX  = {IDX_W{1'b1}};
    localparam logic [CNT_W-1:0]  EC_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  EC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  ZR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] D_ZERO  = {DATA_W{1'b0}};

    // Output register and bookkeeping state
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_value_q, out_value_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
    logic              out_last_q,  out_last_d;
    logic [IDX_W-1:0]  zr_q,        zr_d;
    logic [CNT_W-1:0]  ec_q,        ec_d;
    logic [CNT_W-1:0]  pend_q,      pend_d;   // count of the plane whose last entry is queued
    logic              cnt_valid_q, cnt_valid_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              cnt_ovf_q,   cnt_ovf_d;

    logic [DATA_W-1:0] elem_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              emit_s;
    logic              load_s;
    logic              xfer_s;
    logic [CNT_W-1:0]  ec_inc_s;

    // Element as seen by the encoder (optionally ReLU-clamped)
    always_comb begin
`ifdef SPARSE_ENC_RELU_EN
        if (in_data[DATA_W-1]) begin
            elem_s = D_ZERO;
        end else begin
            elem_s = in_data;
        end
`else
        elem_s = in_data;
`endif
    end

    // Handshake qualifiers and emit decision for the current element
    always_comb begin
        in_ready_s = !out_valid_q || out_ready;
        accept_s   = in_valid && in_ready_s;
        emit_s     = in_last || (elem_s != D_ZERO) || (zr_q == ZR_MAX);
        load_s     = accept_s && emit_s;
        xfer_s     = out_valid_q && out_ready;
        if (ec_q == EC_MAX) begin
            ec_inc_s = EC_MAX;
        end else begin
            ec_inc_s = ec_q + EC_ONE;
        end
    end

    // Next-state logic for output register, zero run, counters
    always_comb begin
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        zr_d        = zr_q;
        ec_d        = ec_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        cnt_ovf_d   = cnt_ovf_q;
        cnt_valid_d = xfer_s && out_last_q;

        if (load_s) begin
            // A load may coincide with a transfer: the register is simply replaced.
            out_valid_d = 1'b1;
            out_value_d = elem_s;
            out_index_d = zr_q;
            out_last_d  = in_last;
            if (ec_q == EC_MAX) begin
                cnt_ovf_d = 1'b1;
            end else begin
                cnt_ovf_d = cnt_ovf_q;
            end
            if (in_last) begin
                pend_d = ec_inc_s;
                ec_d   = {CNT_W{1'b0}};
            end else begin
                ec_d   = ec_inc_s;
            end
        end else if (xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            if (emit_s) begin
                zr_d = {IDX_W{1'b0}};
            end else begin
                zr_d = zr_q + ZR_ONE;
            end
        end else begin
            zr_d = zr_q;
        end

        // Publish the plane count as its closing entry leaves
        if (xfer_s && out_last_q) begin
            cnt_d = pend_q;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_value_q <= {DATA_W{1'b0}};
            out_index_q <= {IDX_W{1'b0}};
            out_last_q  <= 1'b0;
            zr_q        <= {IDX_W{1'b0}};
            ec_q        <= {CNT_W{1'b0}};
            pend_q      <= {CNT_W{1'b0}};
            cnt_valid_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            cnt_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            zr_q        <= zr_d;
            ec_q        <= ec_d;
            pend_q      <= pend_d;
            cnt_valid_q <= cnt_valid_d;
            cnt_q       <= cnt_d;
            cnt_ovf_q   <= cnt_ovf_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign cnt_valid = cnt_valid_q;
    assign cnt       = cnt_q;
    assign cnt_ovf   = cnt_ovf_q;

endmodule
